// File: rtl/adc_avg_frontend.sv
// adc_avg_frontend: block averager between the raw ADC and the tracking
// controller. Sums 2^AVG_LOG2 accepted samples, then presents the floor
// average on x with a one-cycle data_valid strobe. Flags clipped samples
// (overrange, aligned with data_valid) and a stalled ADC (timeout_err, sticky
// until enable drops).
//
// Optional build macro: ADC_AVG_OFFSET_EN adds input adc_offset. When it is
// defined, each accepted sample has the offset subtracted and the result
// saturated before accumulation.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   enable       run request
//   adc_valid    sample strobe
//   adc_sample   signed sample, SAMPLE_W bits
//   adc_offset   signed offset (ADC_AVG_OFFSET_EN only)
//   x            block average, sign-extended to OUT_W
//   data_valid   one-cycle strobe, x updated on the same edge
//   overrange    block contained a clipped sample
//   timeout_err  ADC stall detected
//   state_o      0 IDLE, 1 ACCUM, 2 FAULT
module adc_avg_frontend #(
  parameter int SAMPLE_W = 18,
  parameter int AVG_LOG2 = 4,
  parameter int OUT_W    = 36,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_sample,
`ifdef ADC_AVG_OFFSET_EN
  input  logic [SAMPLE_W-1:0] adc_offset,
`endif
  output logic [OUT_W-1:0]    x,
  output logic                data_valid,
  output logic                overrange,
  output logic                timeout_err,
  output logic [1:0]          state_o
);

  localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WD_W-1:0]    wdog_q;
  logic               ovr_q;
  logic [OUT_W-1:0]   x_q;
  logic               dv_q;
  logic               overrange_q;
  logic               timeout_q;

  logic               clip_d;
  logic [SAMPLE_W-1:0] samp_d;
  logic [ACC_W-1:0]   acc_sum_d;
  logic [SAMPLE_W-1:0] avg_d;
  logic [OUT_W-1:0]   x_d;

  // Clip detection always looks at the raw converter code.
  assign clip_d = (adc_sample == S_MAX) || (adc_sample == S_MIN);

`ifdef ADC_AVG_OFFSET_EN
  // Offset subtraction in one extra bit, then saturate back to SAMPLE_W.
  logic [SAMPLE_W:0] diff_d;
  assign diff_d = {adc_sample[SAMPLE_W-1], adc_sample} - {adc_offset[SAMPLE_W-1], adc_offset};
  always_comb begin
    samp_d = diff_d[SAMPLE_W-1:0];
    if (diff_d[SAMPLE_W] != diff_d[SAMPLE_W-1]) begin
      samp_d = diff_d[SAMPLE_W] ? S_MIN : S_MAX;
    end
  end
`else
  assign samp_d = adc_sample;
`endif

  assign acc_sum_d = acc_q + {{AVG_LOG2{samp_d[SAMPLE_W-1]}}, samp_d};
  // Dropping the low bits of a two's-complement sum is a floor divide.
  assign avg_d = acc_sum_d[ACC_W-1:AVG_LOG2];
  assign x_d   = {{(OUT_W-SAMPLE_W){avg_d[SAMPLE_W-1]}}, avg_d};

  // Control FSM with accumulator, counter, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      ovr_q       <= 1'b0;
      x_q         <= '0;
      dv_q        <= 1'b0;
      overrange_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          acc_q  <= '0;
          cnt_q  <= '0;
          wdog_q <= '0;
          ovr_q  <= 1'b0;
          if (enable) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            ovr_q   <= 1'b0;
          end else if (adc_valid) begin
            wdog_q <= '0;
            if (&cnt_q) begin
              x_q         <= x_d;
              overrange_q <= ovr_q | clip_d;
              dv_q        <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovr_q       <= 1'b0;
            end else begin
              acc_q <= acc_sum_d;
              cnt_q <= cnt_q + CNT_W'(1);
              ovr_q <= ovr_q | clip_d;
            end
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th idle clock: abandon the block.
            state_q   <= ST_FAULT;
            timeout_q <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            ovr_q     <= 1'b0;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_FAULT: begin
          timeout_q <= 1'b1;
          if (!enable) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          acc_q   <= '0;
          cnt_q   <= '0;
          wdog_q  <= '0;
          ovr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_q;
  assign data_valid  = dv_q;
  assign overrange   = overrange_q;
  assign timeout_err = timeout_q;
  assign state_o     = state_q;

endmodule
